// File: rtl/gpio_out_pkg.sv
`timescale 1ns/1ps
// gpio_out_pkg
// Shared definitions for the GPIO output controller: the per-channel mode
// encoding and a helper that sizes index buses so they never collapse to zero width.
package gpio_out_pkg;

    localparam int MODE_W = 2;

    // Per-channel output behaviour. The encoding matches the wr_mode port.
    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Bits needed to index n items. This returns at least 1, so a one-channel
    // build still has a legal (unused) index bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_out_channel.sv
`timescale 1ns/1ps
// gpio_out_channel
// One GPIO output channel. It holds the channel's mode and value registers plus
// the blink half-period counter and blink phase, and produces the unregistered
// pin level. The time-base tick and the shared PWM counter come from the parent.
module gpio_out_channel
    import gpio_out_pkg::*;
#(
    parameter int VAL_W = 8
)
(
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic              load,       // write strobe already decoded for this channel
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [VAL_W-1:0]  wr_value,
    input  logic              tick,
    input  logic [VAL_W-1:0]  pwm_cnt,
    output logic              level
);

    mode_t            mode;
    logic [VAL_W-1:0] value;
    logic [VAL_W-1:0] blink_cnt;
    logic             blink_state;

    // Configuration and blink phase. A write restarts the phase and takes
    // priority over a coincident tick, so that tick is dropped for this channel only.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would create order-dependent races.
        if (!Resetn) begin
            mode        <= MODE_OFF;
            value       <= '0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (load) begin
            mode        <= mode_t'(wr_mode);
            value       <= wr_value;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (tick && (mode == MODE_BLINK)) begin
            if (blink_cnt == value) begin
                blink_cnt   <= '0;
                blink_state <= ~blink_state;
            end else begin
                blink_cnt <= blink_cnt + VAL_W'(1);
            end
        end
    end

    // Pin level selected by the mode. PWM is high while the shared counter is
    // below the duty value, so value 0 never drives the pin high.
    always_comb begin
        // NOTE: the default is assigned first so no path leaves level
        // unassigned, which would otherwise infer a latch.
        level = 1'b0;
        case (mode)
            MODE_OFF:   level = 1'b0;
            MODE_ON:    level = 1'b1;
            MODE_BLINK: level = blink_state;
            MODE_PWM:   level = (pwm_cnt < value);
            default:    level = 1'b0;
        endcase
    end

endmodule

// File: rtl/gpio_out_ctrl.sv
`timescale 1ns/1ps
// gpio_out_ctrl
// N-channel GPIO output controller for the 40-pin header. Each channel is set
// to OFF, ON, BLINK or PWM by a one-cycle write strobe. A prescaler produces the
// time-base tick, a shared counter provides the PWM ramp, and every pin is registered.
// Optional build macro GPIO_OUT_INVERT_EN adds an out_invert input that is XORed
// with the channel levels before the output register.
module gpio_out_ctrl
    import gpio_out_pkg::*;
#(
    parameter int CHANNELS = 32,     // 1..32
    parameter int TICK_DIV = 50000,  // clock cycles per tick, >= 2
    parameter int VAL_W    = 8       // blink half-period / PWM duty width
)
(
    input  logic                           CLOCK_50,
    input  logic                           Resetn,
    input  logic                           wr_en,
    input  logic [idx_width(CHANNELS)-1:0] wr_chan,
    input  logic [MODE_W-1:0]              wr_mode,
    input  logic [VAL_W-1:0]               wr_value,
`ifdef GPIO_OUT_INVERT_EN
    input  logic [CHANNELS-1:0]            out_invert,
`endif
    output logic                           tick,
    output logic [CHANNELS-1:0]            GPIO
);

    localparam int                  CHAN_W     = idx_width(CHANNELS);
    localparam int                  PRESC_W    = idx_width(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0]  presc;
    logic [VAL_W-1:0]    pwm_cnt;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] pin_next;

    // The tick is a decode of the prescaler's last count, so it lasts exactly
    // one cycle and is low in reset because the count restarts at 0.
    assign tick = (presc == PRESC_LAST);

    // Prescaler: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Shared PWM ramp: advances once per tick and wraps naturally from max to 0.
    // Writes never touch it, so all PWM channels stay phase-aligned.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + VAL_W'(1);
        end
    end

    // Write decode: one strobe per channel. An index at or above CHANNELS
    // matches no channel, so that write is dropped.
    always_comb begin
        load = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load[i] = wr_en && (wr_chan == CHAN_W'(i));
        end
    end

    // Channel instances.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        gpio_out_channel #(
            .VAL_W (VAL_W)
        ) u_chan (
            .CLOCK_50 (CLOCK_50),
            .Resetn   (Resetn),
            .load     (load[g]),
            .wr_mode  (wr_mode),
            .wr_value (wr_value),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt),
            .level    (level[g])
        );
    end

    // Pin polarity applied before the output register.
`ifdef GPIO_OUT_INVERT_EN
    assign pin_next = level ^ out_invert;
`else
    assign pin_next = level;
`endif

    // Output register. Pins are 0 in reset even when inverted; the inversion
    // shows from the first edge after reset is released.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            GPIO <= '0;
        end else begin
            GPIO <= pin_next;
        end
    end

endmodule

// File: tb/tb_gpio_out_ctrl.sv
`timescale 1ns/1ps
// tb_gpio_out_ctrl
// Scoreboard bench for gpio_out_ctrl (CHANNELS=8, TICK_DIV=4, VAL_W=4).
// Stimulus pushes {edge, source, mask, expected} items, and a negedge monitor
// compares them when the edge count matches. A second 5-channel instance
// exercises writes to indices beyond the channel count.
module tb_gpio_out_ctrl;
    import gpio_out_pkg::*;

`ifdef GPIO_OUT_INVERT_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       wr_en;
    logic [2:0] wr_chan;
    logic [1:0] wr_mode;
    logic [3:0] wr_value;
    logic       tick;
    logic [7:0] GPIO;

    logic       wr_en2;
    logic [2:0] wr_chan2;
    logic [1:0] wr_mode2;
    logic [3:0] wr_value2;
    logic       tick2;
    logic [4:0] GPIO2;

`ifdef GPIO_OUT_INVERT_EN
    logic [7:0] out_invert;
    logic [4:0] out_invert2;
`endif

    gpio_out_ctrl #(.CHANNELS(8), .TICK_DIV(4), .VAL_W(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .wr_en      (wr_en),
        .wr_chan    (wr_chan),
        .wr_mode    (wr_mode),
        .wr_value   (wr_value),
`ifdef GPIO_OUT_INVERT_EN
        .out_invert (out_invert),
`endif
        .tick       (tick),
        .GPIO       (GPIO)
    );

    gpio_out_ctrl #(.CHANNELS(5), .TICK_DIV(4), .VAL_W(4)) dut2 (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .wr_en      (wr_en2),
        .wr_chan    (wr_chan2),
        .wr_mode    (wr_mode2),
        .wr_value   (wr_value2),
`ifdef GPIO_OUT_INVERT_EN
        .out_invert (out_invert2),
`endif
        .tick       (tick2),
        .GPIO       (GPIO2)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Rising edges since the last reset release. Ticks are consumed on edges
    // that are multiples of 4, and the PWM count after edge e is (e/4)%16.
    int edge_cnt;
    always @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    typedef enum {SRC_GPIO, SRC_TICK, SRC_GPIO2} src_t;
    typedef struct {
        int         at;
        src_t       src;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
        end
    endtask

    // Queue an expectation for the sample taken after edge 'at'. GPIO
    // expectations are written for the non-inverted pin and corrected here.
    function automatic void push(input int at, input src_t src, input logic [7:0] mask,
                                 input logic [7:0] exp, input string name);
        logic [7:0] e;
        e = exp & mask;
        if (src == SRC_GPIO) e = e ^ (INV & mask);
        sb.push_back('{at, src, mask, e, name});
    endfunction

    // Expected blink pin at edge e for a write at edge n: count the ticks in
    // (n, e-1]; the phase flips after every v+1 ticks.
    function automatic logic blink_pin(input int n, input int v, input int e);
        int c;
        c = (e - 1) / 4 - n / 4;
        return ((c / (v + 1)) % 2) == 1;
    endfunction

    // Expected PWM pin at edge e: the counter seen before edge e is below the duty.
    function automatic logic pwm_pin(input int v, input int e);
        return (((e - 1) / 4) % 16) < v;
    endfunction

    // Monitor: compares every due item and flags any item whose edge has passed.
    logic [7:0] act;
    always @(negedge CLOCK_50) begin
        if (Resetn) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == edge_cnt) begin
                    case (sb[i].src)
                        SRC_GPIO:  act = GPIO;
                        SRC_TICK:  act = {7'b0, tick};
                        default:   act = {3'b0, GPIO2};
                    endcase
                    check(sb[i].name, act & sb[i].mask, sb[i].exp);
                    sb.delete(i);
                end else if (sb[i].at < edge_cnt) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_missed: item for edge %0d not sampled, now edge %0d",
                             sb[i].name, sb[i].at, edge_cnt);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic wait_mod(input int m);
        while ((edge_cnt % 4) != m) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Drive a write for one cycle. Call this #1 after a rising edge; n
    // returns the edge that sampled the strobe.
    task automatic do_write(input int chan, input mode_t mode, input int value, output int n);
        wr_chan  = 3'(chan);
        wr_mode  = mode;
        wr_value = 4'(value);
        wr_en    = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n     = edge_cnt;
        wr_en = 1'b0;
    endtask

    task automatic do_write2(input int chan, input mode_t mode, output int n);
        wr_chan2  = 3'(chan);
        wr_mode2  = mode;
        wr_value2 = 4'd0;
        wr_en2    = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n      = edge_cnt;
        wr_en2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, n0, np, hi;
        wr_en = 1'b0; wr_chan = '0; wr_mode = '0; wr_value = '0;
        wr_en2 = 1'b0; wr_chan2 = '0; wr_mode2 = '0; wr_value2 = '0;
`ifdef GPIO_OUT_INVERT_EN
        out_invert  = 8'hFF;
        out_invert2 = 5'h00;
`endif

        // Reset state while Resetn is held low.
        #12;
        check("reset_gpio", GPIO, 8'h00);
        check("reset_tick", {7'b0, tick}, 8'h00);
        #10 Resetn = 1'b1;

        // Idle after release: all pins follow the OFF level, and the tick pulses on every 4th cycle.
        for (int e = 1; e <= 8; e++) begin
            push(e, SRC_GPIO, 8'hFF, 8'h00, "idle_gpio");
            push(e, SRC_TICK, 8'h01, {7'b0, (e % 4) == 3}, "tick_pulse");
        end
        wait_edge(8);

        // Static ON/OFF with the 2-cycle strobe-to-pin latency.
        do_write(3, MODE_ON, 0, n);
        push(n,     SRC_GPIO, 8'h08, 8'h00, "ch3_on_early");
        push(n + 1, SRC_GPIO, 8'hFF, 8'h08, "ch3_on");
        wait_edge(n + 2);
        do_write(3, MODE_OFF, 0, n);
        push(n,     SRC_GPIO, 8'h08, 8'h08, "ch3_off_early");
        push(n + 1, SRC_GPIO, 8'hFF, 8'h00, "ch3_off");
        wait_edge(n + 2);

        // Out-of-range channel indices on the 5-channel instance are ignored.
        do_write2(7, MODE_ON, n);
        do_write2(5, MODE_ON, n2);
        for (int k = 0; k <= 3; k++) push(n2 + k, SRC_GPIO2, 8'h1F, 8'h00, "oob_ignored");
        wait_edge(n2 + 3);
        do_write2(4, MODE_ON, n);
        push(n + 1, SRC_GPIO2, 8'h1F, 8'h10, "ch4_on_small");
        wait_edge(n + 2);

        // Channel 0 ON, then an asynchronous reset mid-cycle while the tick is high.
        do_write(0, MODE_ON, 0, n);
        push(n + 1, SRC_GPIO, 8'hFF, 8'h01, "ch0_on");
        wait_edge(n + 2);
        wait_mod(3);
        check("pre_reset_tick", {7'b0, tick}, 8'h01);
        check("pre_reset_gpio", GPIO, 8'h01 ^ INV);
        #2 Resetn = 1'b0;
        #1;
        check("async_reset_gpio", GPIO, 8'h00);
        check("async_reset_tick", {7'b0, tick}, 8'h00);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_hold_gpio", GPIO, 8'h00);
        @(negedge CLOCK_50);
        #1 Resetn = 1'b1;
        for (int e = 1; e <= 6; e++) push(e, SRC_GPIO, 8'hFF, 8'h00, "release_idle");
        wait_edge(6);

        // Blink: value 2 gives 3-tick half periods, and value 0 toggles on every tick.
        do_write(1, MODE_BLINK, 2, n);
        for (int k = 1; k <= 60; k++)
            push(n + k, SRC_GPIO, 8'h02, {6'b0, blink_pin(n, 2, n + k), 1'b0}, "blink_v2");
        wait_edge(n + 60);
        do_write(1, MODE_BLINK, 0, n);
        for (int k = 1; k <= 24; k++)
            push(n + k, SRC_GPIO, 8'h02, {6'b0, blink_pin(n, 0, n + k), 1'b0}, "blink_v0");
        wait_edge(n + 24);

        // PWM duty 4, 0 and 15 on channel 2: per-edge waveform plus duty over one full period.
        for (int j = 0; j < 3; j++) begin
            int v;
            v = (j == 0) ? 4 : (j == 1) ? 0 : 15;
            do_write(2, MODE_PWM, v, n);
            for (int k = 1; k <= 68; k++)
                push(n + k, SRC_GPIO, 8'h04, {5'b0, pwm_pin(v, n + k), 2'b0},
                     $sformatf("pwm_v%0d", v));
            wait_edge(n + 1);
            hi = 0;
            repeat (64) begin
                @(negedge CLOCK_50);
                hi += int'(GPIO[2] ^ INV[2]);
            end
            check($sformatf("pwm_duty_v%0d", v), 8'(hi), 8'(v * 4));
            wait_edge(n + 68);
        end

        // Collision: a BLINK rewrite sampled on the tick edge restarts the phase,
        // and the channel 2 PWM waveform keeps running undisturbed.
        do_write(2, MODE_PWM, 4, np);
        do_write(1, MODE_BLINK, 2, n0);
        for (int k = 1; k <= 20; k++)
            push(n0 + k, SRC_GPIO, 8'h02, {6'b0, blink_pin(n0, 2, n0 + k), 1'b0}, "blink_pre_coll");
        for (int k = 1; k <= 80; k++)
            push(np + k, SRC_GPIO, 8'h04, {5'b0, pwm_pin(4, np + k), 2'b0}, "pwm_during_coll");
        wait_edge(n0 + 20);
        wait_mod(3);
        check("collision_tick", {7'b0, tick}, 8'h01);
        do_write(1, MODE_BLINK, 2, n);
        for (int k = 1; k <= 26; k++)
            push(n + k, SRC_GPIO, 8'h02, {6'b0, (k >= 13 && k <= 24), 1'b0}, "blink_coll");
        wait_edge(np + 81);

        // Every queued expectation must have been sampled.
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge CLOCK_50);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d items left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
